// File: rtl/tile_console_writer_if.sv
// Character stream in, tile-RAM write port and cursor out, for the console writer.
// slave is the writer's view; master is the producer/observer side.
interface tile_console_writer_if #(
  parameter int COL_BITS = 7,
  parameter int ROW_BITS = 6
);
  logic [7:0]                   ch_dat;
  logic                         ch_vld;
  logic                         ch_rdy;
  logic [ROW_BITS+COL_BITS-1:0] waddr;
  logic [7:0]                   wdata;
  logic                         wen;
  logic [COL_BITS-1:0]          cur_col;
  logic [ROW_BITS-1:0]          cur_row;
  logic                         busy;

  modport master (
    output ch_dat, ch_vld,
    input  ch_rdy, waddr, wdata, wen, cur_col, cur_row, busy
  );

  modport slave (
    input  ch_dat, ch_vld,
    output ch_rdy, waddr, wdata, wen, cur_col, cur_row, busy
  );
endinterface

// File: rtl/tile_console_writer.sv
// Tile RAM write sequencer: prints codes at a cursor, handles CR/LF/BS/FF, clears with FILL_CHAR.
// Writes registered (decision t -> RAM port t+1); ch_rdy only in IDLE, no input buffering.
module tile_console_writer #(
  parameter int         COLS      = 80,
  parameter int         ROWS      = 60,
  parameter int         COL_BITS  = 7,
  parameter int         ROW_BITS  = 6,
  parameter logic [7:0] FILL_CHAR = 8'h20
) (
  input  logic                 clk,
  input  logic                 rst,
  tile_console_writer_if.slave bus
);

  localparam int                  AW       = ROW_BITS + COL_BITS;
  localparam logic [COL_BITS-1:0] LAST_COL = COL_BITS'(COLS - 1);
  localparam logic [ROW_BITS-1:0] LAST_ROW = ROW_BITS'(ROWS - 1);
  localparam logic [COL_BITS-1:0] ONE_COL  = COL_BITS'(1);
  localparam logic [ROW_BITS-1:0] ONE_ROW  = ROW_BITS'(1);

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [1:0] {
    CLEAR  = 2'd0,
    ROWCLR = 2'd1,
    IDLE   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [COL_BITS-1:0] clr_col_q, clr_col_d;
  logic [ROW_BITS-1:0] clr_row_q, clr_row_d;
  logic [COL_BITS-1:0] cur_col_q, cur_col_d;
  logic [ROW_BITS-1:0] cur_row_q, cur_row_d;
  logic                wen_q, wen_d;
  logic [AW-1:0]       waddr_q, waddr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic                do_newline;
  logic                printable;

  assign printable = (bus.ch_dat >= 8'h20) && (bus.ch_dat <= 8'h7E);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_col_q <= '0;
      clr_row_q <= '0;
      cur_col_q <= '0;
      cur_row_q <= '0;
      wen_q     <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      clr_col_q <= clr_col_d;
      clr_row_q <= clr_row_d;
      cur_col_q <= cur_col_d;
      cur_row_q <= cur_row_d;
      wen_q     <= wen_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_col_d  = clr_col_q;
    clr_row_d  = clr_row_q;
    cur_col_d  = cur_col_q;
    cur_row_d  = cur_row_q;
    wen_d      = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    do_newline = 1'b0;

    unique case (state_q)
      CLEAR: begin
        wen_d   = 1'b1;
        waddr_d = {clr_row_q, clr_col_q};
        wdata_d = FILL_CHAR;
        if (clr_col_q == LAST_COL) begin
          clr_col_d = '0;
          if (clr_row_q == LAST_ROW) begin
            clr_row_d = '0;
            state_d   = IDLE;
          end else begin
            clr_row_d = clr_row_q + ONE_ROW;
          end
        end else begin
          clr_col_d = clr_col_q + ONE_COL;
        end
      end

      // The cursor row is already the freshly entered row, so it doubles as the clear row.
      ROWCLR: begin
        wen_d   = 1'b1;
        waddr_d = {cur_row_q, clr_col_q};
        wdata_d = FILL_CHAR;
        if (clr_col_q == LAST_COL) begin
          clr_col_d = '0;
          state_d   = IDLE;
        end else begin
          clr_col_d = clr_col_q + ONE_COL;
        end
      end

      IDLE: begin
        if (bus.ch_vld) begin
          if (printable) begin
            wen_d   = 1'b1;
            waddr_d = {cur_row_q, cur_col_q};
            wdata_d = bus.ch_dat;
            if (cur_col_q == LAST_COL) begin
              do_newline = 1'b1;
            end else begin
              cur_col_d = cur_col_q + ONE_COL;
            end
          end else begin
            case (bus.ch_dat)
              CH_CR: cur_col_d = '0;
              CH_LF: do_newline = 1'b1;
              CH_BS: begin
                if (cur_col_q != '0) begin
                  cur_col_d = cur_col_q - ONE_COL;
                  wen_d     = 1'b1;
                  waddr_d   = {cur_row_q, cur_col_q - ONE_COL};
                  wdata_d   = FILL_CHAR;
                end
              end
              CH_FF: begin
                cur_col_d = '0;
                cur_row_d = '0;
                clr_col_d = '0;
                clr_row_d = '0;
                state_d   = CLEAR;
              end
              default: ;
            endcase
          end
        end
      end

      default: begin
        clr_col_d = '0;
        clr_row_d = '0;
        cur_col_d = '0;
        cur_row_d = '0;
        state_d   = CLEAR;
      end
    endcase

    if (do_newline) begin
      cur_col_d = '0;
      cur_row_d = (cur_row_q == LAST_ROW) ? '0 : cur_row_q + ONE_ROW;
      clr_col_d = '0;
      state_d   = ROWCLR;
    end
  end

  assign bus.ch_rdy  = (state_q == IDLE);
  assign bus.busy    = (state_q != IDLE);
  assign bus.wen     = wen_q;
  assign bus.waddr   = waddr_q;
  assign bus.wdata   = wdata_q;
  assign bus.cur_col = cur_col_q;
  assign bus.cur_row = cur_row_q;

  a_col_in_range: assert property (@(posedge clk) disable iff (rst)
    wen_q |-> (int'(waddr_q[COL_BITS-1:0]) < COLS));
  a_row_in_range: assert property (@(posedge clk) disable iff (rst)
    wen_q |-> (int'(waddr_q[AW-1:COL_BITS]) < ROWS));
  a_cursor_in_range: assert property (@(posedge clk) disable iff (rst)
    (int'(cur_col_q) < COLS) && (int'(cur_row_q) < ROWS));

endmodule

// File: doc/tile_console_writer.md
Name: tile_console_writer

Overview:
- Sequences the write port of the tile (character-code) RAM that the text renderer reads.
- Accepts a stream of 8-bit character codes over a valid/ready handshake and keeps a cursor.
- Writes printable codes at the cursor and interprets CR, LF, BS and FF.
- Performs full-screen and single-row clears with FILL_CHAR, one RAM write per cycle.

Parameters:
- COLS, 80, visible columns per row.
- ROWS, 60, visible rows.
- COL_BITS, 7, column field width of the RAM address.
- ROW_BITS, 6, row field width of the RAM address.
- FILL_CHAR, 8'h20, code written by clears and backspace.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- ch_i  in  8  character code.
- ch_valid_i  in  1  ch_i valid.
- ch_ready_o  out  1  block can accept; transfer occurs when ch_valid_i & ch_ready_o.
- waddr_o  out  ROW_BITS+COL_BITS  RAM write address {row, col}.
- wdata_o  out  8  RAM write data.
- wen_o  out  1  RAM write enable, one cycle per write.
- cur_col_o  out  COL_BITS  cursor column.
- cur_row_o  out  ROW_BITS  cursor row.
- busy_o  out  1  high whenever state != IDLE.

Behaviour:
- States: CLEAR, ROWCLR, IDLE. ch_ready_o = (state==IDLE), combinational from the state register; busy_o = !ch_ready_o.
- Write outputs (wen_o, waddr_o, wdata_o) are registered. A write decided in cycle t appears on the outputs in cycle t+1.
- Reset: state=CLEAR, clear counters=0, cursor=(0,0), wen_o=0, waddr_o=0, wdata_o=0.
- Reset asserted mid-operation aborts that operation and restarts the full CLEAR from (0,0).
- CLEAR:
  - Writes FILL_CHAR to every cell in row-major order: row 0..ROWS-1, col 0..COLS-1.
  - Exactly ROWS*COLS writes on consecutive cycles.
  - With cycle 0 as the first cycle after rst falls, writes appear in cycles 1..ROWS*COLS and the state is IDLE in cycle ROWS*COLS.
  - Cursor is held at (0,0). Addresses with col>=COLS or row>=ROWS are never written.
- IDLE, on accept of code c in cycle t:
  - Printable (0x20..0x7E): write c at {row,col} in cycle t+1.
    - If col<COLS-1: col+1.
    - Else: newline.
  - 0x0D (CR): col=0; no write.
  - 0x0A (LF): newline.
  - 0x08 (BS): if col>0, col-1 and write FILL_CHAR at the new position in cycle t+1. If col==0: no-op.
  - 0x0C (FF): cursor=(0,0); state=CLEAR (full clear, same timing as after reset, counted from cycle t+1).
  - Any other code (0x00..0x1F not listed above, 0x7F..0xFF): accepted and ignored.
- Newline:
  - col=0; row = (row==ROWS-1) ? 0 : row+1.
  - state=ROWCLR in cycle t+1.
  - ROWCLR writes FILL_CHAR to {newrow, 0..COLS-1} in cycles t+2..t+COLS+1.
  - State is IDLE (ready high) in cycle t+COLS+1.
  - On printable wrap, the character write (cycle t+1) precedes the first clear write.
- Cursor outputs update in cycle t+1 for every accepted code.
- ch_valid_i held while busy: nothing accepted and the data is not sampled. The code is accepted on the first IDLE cycle. No input buffering.
- Read side of the RAM is untouched; this block owns only the write port.

Test Plan:
- Reset, then release rst -> exactly 4800 wen_o pulses of 0x20 with addresses {0,0},{0,1}..{0,79},{1,0}..{59,79}; ch_ready_o rises in cycle 4800; no write to col>=80.
- After clear, send 'A'(0x41), 'B' back-to-back -> writes {0,0}=0x41 and {0,1}=0x42 in consecutive cycles; cursor (0,2); ch_ready_o never drops.
- Cursor at (59,79), send 'Z' -> write {59,79}=0x5A, cursor (0,0), then 80 writes of 0x20 to {0,0..79}; ch_ready_o low exactly 80 cycles; 'Q' offered during busy is written at {0,0} after.
- Cursor (3,0), send BS -> no write, cursor unchanged. Then 'x', BS -> writes {3,0}=0x78 then {3,0}=0x20; cursor (3,0).
- Cursor (10,5), send CR, LF, 0x07 -> cursor (10,0), then (11,0) with row 11 cleared (80 writes); 0x07 accepted, no write, no cursor change.
- During an FF-triggered CLEAR, pulse rst at write 1000 -> the next write after rst falls is {0,0}; the full 4800-write sequence follows; cursor (0,0).
